// File: rtl/aes_result_display_sequencer.sv
// Captures a 128-bit cipher state and presents its 16 bytes, MSB byte first, as
// 3-digit BCD for the seven-segment decoders, using a sequential double-dabble engine.
module aes_result_display_sequencer #(
  parameter int unsigned DWELL  = 16,
  parameter bit          REPEAT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [0:127] data_in,
  output logic         busy,
  output logic [3:0]   byte_idx,
  output logic [3:0]   units,
  output logic [3:0]   tens,
  output logic [3:0]   hunds,
  output logic         digit_valid,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, CONVERT, LATCH, SHOW} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t        state, state_next;
  logic [0:127]  data_q;
  logic [19:0]   work;        // {hunds, tens, units, binary}
  logic [2:0]    iter;
  logic [15:0]   dwell_cnt;
  logic          dv_q;
  logic          done_q;
  logic [7:0]    next_byte;

  // One shift-add-3 iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] w);
    logic [19:0] a;
    a = w;
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  always_comb begin
    next_byte = data_q[{byte_idx + 4'd1, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = CONVERT;
    end else if (enable) begin
      case (state)
        IDLE:    state_next = IDLE;
        CONVERT: if (iter == 3'd7) state_next = LATCH;
        LATCH:   state_next = SHOW;
        SHOW:    if (dwell_cnt == 16'd0)
                   state_next = (byte_idx == 4'd15 && !REPEAT) ? IDLE : CONVERT;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      work      <= '0;
      iter      <= '0;
      dwell_cnt <= '0;
      byte_idx  <= '0;
      hunds     <= '0;
      tens      <= '0;
      units     <= '0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Pulses are consumed only on enabled cycles, so a pulse due while frozen waits.
      if (enable) begin
        dv_q   <= 1'b0;
        done_q <= 1'b0;
      end
      if (load) begin
        data_q   <= data_in;
        byte_idx <= 4'd0;
        work     <= {12'd0, data_in[0:7]};
        iter     <= 3'd0;
        done_q   <= 1'b0;
      end else if (enable) begin
        case (state)
          CONVERT: begin
            work <= dd_step(work);
            iter <= iter + 3'd1;
          end
          LATCH: begin
            hunds     <= work[19:16];
            tens      <= work[15:12];
            units     <= work[11:8];
            dv_q      <= 1'b1;
            dwell_cnt <= DWELL_LAST;
          end
          SHOW: begin
            if (dwell_cnt == 16'd0) begin
              if (byte_idx == 4'd15) done_q <= 1'b1;
              byte_idx <= byte_idx + 4'd1;
              work     <= {12'd0, next_byte};
              iter     <= 3'd0;
            end else begin
              dwell_cnt <= dwell_cnt - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = (state != IDLE);
  assign digit_valid = dv_q & enable;
  assign done        = done_q & enable;

endmodule

// File: tb/tb_aes_result_display_sequencer.sv
// Directed bench: expected BCD digits per byte are queued at load time and
// compared as digit_valid pulses appear; timing of pulses is checked against load.
module tb_aes_result_display_sequencer;

  localparam int DWELL = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         load;
  logic [0:127] data_in;
  logic         busy;
  logic [3:0]   byte_idx, units, tens, hunds;
  logic         digit_valid, done;

  always #5 clk = ~clk;

  aes_result_display_sequencer #(.DWELL(DWELL), .REPEAT(1'b0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .data_in(data_in),
    .busy(busy), .byte_idx(byte_idx), .units(units), .tens(tens), .hunds(hunds),
    .digit_valid(digit_valid), .done(done)
  );

  typedef struct packed {
    logic [3:0] idx;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int cyc = 0;
  int pass_cnt = 0, total_cnt = 0;
  int dv_count = 0, done_count = 0, dv_cyc = 0, done_cyc = 0, load_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (digit_valid) begin
      dv_count++;
      dv_cyc = cyc;
      if (sb.size() == 0) begin
        check("dv_unexpected", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check("byte_idx", byte_idx, mon_e.idx);
        check("hunds", hunds, mon_e.h);
        check("tens", tens, mon_e.t);
        check("units", units, mon_e.u);
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic push_vec(input logic [0:127] v);
    logic [7:0] b;
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      b     = v[8*k +: 8];
      e.idx = 4'(k);
      e.h   = 4'(b / 8'd100);
      e.t   = 4'((b / 8'd10) % 8'd10);
      e.u   = 4'(b % 8'd10);
      sb.push_back(e);
    end
  endtask

  task automatic do_load(input logic [0:127] v);
    @(negedge clk);
    load    = 1'b1;
    data_in = v;
    push_vec(v);
    @(posedge clk);
    #1;
    load     = 1'b0;
    load_cyc = cyc;
  endtask

  task automatic wait_dv(input int target, input int budget, input string tag);
    int n = 0;
    while (dv_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, (dv_count >= target), 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_timeout", (done_count >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [0:127] v1, v2, v3;
    int base, done_base;
    v1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    v2 = 128'h00ff09643c7e885511223344a5b6c7d8;
    v3 = 128'hdeadbeef0123456789abcdeffedcba98;

    reset = 1'b0; enable = 1'b1; load = 1'b0; data_in = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_byte_idx", byte_idx, 0);
    check("rst_digits", {hunds, tens, units}, 0);
    check("rst_pulses", {digit_valid, done}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    // Full pass of the reference vector.
    base = dv_count;
    do_load(v1);
    check("busy_after_load", busy, 1);
    wait_dv(base + 1, 40, "dv0_timeout");
    check("dv0_latency", dv_cyc - load_cyc, 9);
    wait_dv(base + 2, 40, "dv1_timeout");
    check("dv1_latency", dv_cyc - load_cyc, 9 + 9 + DWELL);
    wait_done(1, 400);
    check("done_latency", done_cyc - load_cyc, 16 * (9 + DWELL));
    check("pass_dv_count", dv_count - base, 16);
    check("busy_after_done", busy, 0);
    check("sb_empty_pass", sb.size(), 0);
    repeat (5) @(negedge clk);
    check("idle_hold_digits", {hunds, tens, units}, 12'h090);
    check("idle_byte_idx", byte_idx, 0);
    check("done_single", done_count, 1);

    // Boundary bytes, then freeze enable mid-CONVERT of byte 3.
    base = dv_count;
    do_load(v2);
    wait_dv(base + 3, 80, "v2_dv2_timeout");
    while (cyc < load_cyc + 41) @(negedge clk);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("freeze_byte_idx", byte_idx, 3);
    check("freeze_no_dv", dv_count - base, 3);
    enable = 1'b1;
    wait_dv(base + 4, 40, "v2_dv3_timeout");
    check("freeze_dv_latency", dv_cyc - load_cyc, 3 * (9 + DWELL) + 9 + 20);

    // Abort during byte 7's dwell with a new load.
    wait_dv(base + 8, 80, "v2_dv7_timeout");
    check("abort_pre_idx", byte_idx, 7);
    done_base = done_count;
    sb.delete();
    base = dv_count;
    do_load(v3);
    check("abort_byte_idx", byte_idx, 0);
    check("abort_digits_held", {hunds, tens, units}, 12'h085);
    wait_dv(base + 1, 40, "v3_dv0_timeout");
    check("abort_dv_latency", dv_cyc - load_cyc, 9);
    check("abort_no_done", done_count, done_base);

    // Asynchronous reset in the middle of SHOW.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_byte_idx", byte_idx, 0);
    check("areset_digits", {hunds, tens, units}, 0);
    check("areset_pulses", {digit_valid, done}, 0);
    sb.delete();
    base = dv_count;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_idle", busy, 0);
    check("post_reset_no_dv", dv_count, base);
    check("post_reset_no_done", done_count, done_base);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/aes_result_display_sequencer.md
Name: aes_result_display_sequencer

Overview:
Downstream consumer of the cipher/inverse-cipher 128-bit output. It captures a 128-bit state on a load pulse and walks through its 16 bytes, most-significant first. Each byte is converted to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine, and the digits are held for a programmable dwell time. Its digit outputs drive the existing BCDtoSSD seven-segment decoders, which replaces the single-byte combinational BCD path at top level.

Parameters:
DWELL, 16, cycles each converted byte is held in SHOW; legal range 1..65535.
REPEAT, 0, 0 = one pass then return to IDLE; 1 = wrap to byte 0 after byte 15 and run until reset or a new load.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
enable  input  1  advance enable; when 0, all counters and the FSM hold.
load  input  1  single-cycle capture strobe for data_in.
data_in  input  [0:127]  state to display; byte k = data_in[8k +: 8], byte 0 = data_in[0:7].
busy  output  1  high in every state except IDLE.
byte_idx  output  4  index of the byte currently shown or being converted.
units  output  4  BCD units digit of the current byte.
tens  output  4  BCD tens digit.
hunds  output  4  BCD hundreds digit (0..2).
digit_valid  output  1  one-cycle pulse when units/tens/hunds update.
done  output  1  one-cycle pulse after byte 15's dwell completes.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; captured register=0; byte_idx, units, tens, hunds=0; busy, digit_valid, done=0. Reset takes effect immediately mid-operation, and no done pulse is generated.
- States: IDLE, CONVERT, LATCH, SHOW.
- IDLE: on a clock edge with load=1, capture data_in, set byte_idx=0, and go to CONVERT. load is honoured regardless of enable.
- CONVERT: the 20-bit working register {12 BCD bits, 8 binary bits} is initialised from the selected byte on entry. The state performs exactly 8 iterations, one per enabled cycle. Each iteration adds 3 to any BCD nibble >=5, then shifts the whole register left by 1. After the 8th iteration, go to LATCH.
- LATCH: one cycle. Register the BCD nibbles onto hunds/tens/units, pulse digit_valid, then go to SHOW.
- Latency: outputs are visible 9 enabled cycles after the edge that sampled load, or after entry to CONVERT for later bytes.
- SHOW: hold for DWELL enabled cycles using a 16-bit down-counter loaded with DWELL-1.
  - On expiry with byte_idx<15: increment byte_idx and go to CONVERT.
  - On expiry with byte_idx=15: pulse done on that cycle. Then byte_idx wraps to 0; the FSM goes to CONVERT if REPEAT=1, else to IDLE.
- Byte period = 9 + DWELL enabled cycles. A full pass = 16*(9+DWELL) cycles.
- Outputs hold their last values through CONVERT and while in IDLE. They only change at LATCH or reset.
- enable=0: FSM, iteration counter, dwell counter and byte_idx freeze. digit_valid and done are never asserted while enable=0; a pulse due is deferred until enable returns.
- load=1 while busy: abort the current pass, recapture data_in, set byte_idx=0, and restart CONVERT on the next cycle. No done pulse is generated for the aborted pass. Digit outputs keep their old values until the new LATCH.
- Same-edge load and SHOW expiry of byte 15: load wins and done is suppressed.
- Arithmetic: maximum input 255 gives hunds<=2. No nibble ever exceeds 9 after conversion.

Test Plan:
- Reset then load data_in=128'h69c4e0d86a7b0430d8cdb78070b4c55a, DWELL=4 -> 9 cycles after load: digit_valid pulses with hunds/tens/units=1/0/5 and byte_idx=0. Next byte 0xc4 -> 1/9/6 exactly 13 cycles later.
- Same vector, full pass -> 16 digit_valid pulses. Last byte 0x5a -> 0/9/0 at byte_idx=15. done pulses 208 cycles after load, then busy=0 (REPEAT=0).
- Byte values 0x00, 0xFF, 0x09, 0x64 -> 0/0/0, 2/5/5, 0/0/9, 1/0/0.
- Hold enable=0 for 20 cycles mid-CONVERT of byte 3 -> byte_idx stays 3, no digit_valid. After release, the digit pulse arrives exactly 20 cycles later than nominal.
- Pulse load with a new vector while byte_idx=7 in SHOW -> byte_idx returns to 0. First new digits appear 9 cycles later, and no done pulse fires for the aborted pass.
- Drive reset low asynchronously mid-SHOW -> all outputs 0 and busy=0 before the next clock edge. After release, the FSM remains in IDLE until load.
